// File: rtl/sonar_echo_responder_if.sv
// Ranging link between a sonar initiator (master) and an echo responder (slave).
// The trigger and distance travel to the responder; echo and status travel back.
interface sonar_echo_responder_if;
    logic       trig;
    logic [8:0] dist_cm;
    logic       echo;
    logic       busy;
    logic       done;

    modport master (output trig, output dist_cm, input echo, input busy, input done);
    modport slave  (input trig, input dist_cm, output echo, output busy, output done);
endinterface

// File: rtl/sonar_echo_responder.sv
// HC-SR04 stand-in: qualifies a synchronized TRIG pulse, waits out the burst time,
// then returns an ECHO pulse whose width encodes the latched distance.
module sonar_echo_responder #(
    parameter int TRIG_MIN_CYCLES = 500,
    parameter int BURST_CYCLES    = 10_000,
    parameter int CYC_PER_CM      = 2_900,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYCLES  = 1_900_000,
    parameter int HOLDOFF_CYCLES  = 500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    sonar_echo_responder_if.slave sonar
);
    localparam int SYNC_STAGES = 2;
    localparam int PROD_MAX    = 511 * CYC_PER_CM;
    localparam int PROD_W      = $clog2(PROD_MAX + 1);
    localparam int MAX_AB      = (BURST_CYCLES > PROD_MAX) ? BURST_CYCLES : PROD_MAX;
    localparam int MAX_CD      = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_MAX     = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int HI_W        = $clog2(TRIG_MIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO_HI, HOLDOFF} state_t;

    state_t            state_reg, state_next;
    logic [HI_W-1:0]   hi_cnt_reg, hi_cnt_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [8:0]        dist_q_reg, dist_q_next;
    logic              echo_reg, echo_next;
    logic              done_reg, done_next;
    logic              armed_reg, armed_next;

    logic              sync_reg [SYNC_STAGES];
    logic              trig_s;
    logic [PROD_W-1:0] prod;
    logic              out_of_range;
    logic [CNT_W-1:0]  echo_w;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sonar.trig;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign trig_s = sync_reg[SYNC_STAGES-1];

    // Width is derived from the latched distance only, so DIST_CM may move freely after t0.
    assign prod         = PROD_W'(dist_q_reg) * PROD_W'(CYC_PER_CM);
    assign out_of_range = (dist_q_reg == 9'd0) || (dist_q_reg > 9'(MAX_CM));
    assign echo_w       = out_of_range ? CNT_W'(TIMEOUT_CYCLES) : CNT_W'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            hi_cnt_reg <= '0;
            cnt_reg    <= '0;
            dist_q_reg <= '0;
            echo_reg   <= 1'b0;
            done_reg   <= 1'b0;
            armed_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            hi_cnt_reg <= hi_cnt_next;
            cnt_reg    <= cnt_next;
            dist_q_reg <= dist_q_next;
            echo_reg   <= echo_next;
            done_reg   <= done_next;
            armed_reg  <= armed_next;
        end
    end

    // Each timed phase loads (length - 1) and leaves when the shared counter reaches zero.
    always_comb begin
        state_next  = state_reg;
        hi_cnt_next = hi_cnt_reg;
        cnt_next    = cnt_reg;
        dist_q_next = dist_q_reg;
        echo_next   = echo_reg;
        done_next   = 1'b0;
        armed_next  = armed_reg;
        case (state_reg)
            IDLE: begin
                if (trig_s && armed_reg) begin
                    state_next  = TRIG_HI;
                    hi_cnt_next = HI_W'(1);
                end else if (!trig_s) begin
                    armed_next = 1'b1;
                end
            end
            TRIG_HI: begin
                if (trig_s) begin
                    if (hi_cnt_reg < HI_W'(TRIG_MIN_CYCLES)) hi_cnt_next = hi_cnt_reg + HI_W'(1);
                end else if (hi_cnt_reg >= HI_W'(TRIG_MIN_CYCLES)) begin
                    state_next  = BURST;
                    dist_q_next = sonar.dist_cm;
                    cnt_next    = CNT_W'(BURST_CYCLES - 1);
                end else begin
                    state_next = IDLE;
                end
            end
            BURST: begin
                if (cnt_reg == '0) begin
                    state_next = ECHO_HI;
                    echo_next  = 1'b1;
                    cnt_next   = echo_w - CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ECHO_HI: begin
                if (cnt_reg == '0) begin
                    state_next = HOLDOFF;
                    echo_next  = 1'b0;
                    done_next  = 1'b1;
                    cnt_next   = CNT_W'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                // A TRIG still held high here must drop once in IDLE before it can re-trigger.
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    armed_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sonar.echo = echo_reg;
    assign sonar.busy = (state_reg != IDLE);
    assign sonar.done = done_reg;
endmodule
